// File: rtl/zepto_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding,
// default datapath widths and the PC step applied after each fetched word.
package zepto_fetch_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  localparam int PC_INC     = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_wdog.sv
// Memory-response watchdog: counts cycles a fetch request waits without an
// ack and raises a sticky error flag once MAX_WAIT such cycles accumulate.
// Ports:
//   clk, Reset  - clock / synchronous active-high reset
//   count_en    - a request is waiting this cycle without an ack
//   clear       - drop the count (ack, redirect or leaving the fetch state)
//   fetch_err   - sticky flag, cleared only by Reset
module fetch_wdog #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic Reset,
  input  logic count_en,
  input  logic clear,
  output logic fetch_err
);

  localparam logic [7:0] LIMIT = 8'(MAX_WAIT);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (Reset) begin
      cnt       <= '0;
      fetch_err <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count_en && cnt != LIMIT) begin
      // Saturates at LIMIT; the flag is set on the edge the count reaches it.
      cnt <= cnt + 8'd1;
      if (cnt == LIMIT - 8'd1)
        fetch_err <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Reads the word at the current PC from instruction
// memory with a req/ack handshake, latches it into the instruction register
// for decode, and closes the PC loop by driving its next value (hold,
// increment or branch redirect). Also handles decode stall back-pressure and
// a memory-response watchdog.
// Ports:
//   clk, Reset                 - clock / synchronous active-high reset
//   pc_in, pc_next             - PC register output / next-value input
//   branch_take, branch_target - redirect from execute
//   stall                      - decode cannot accept the instruction
//   mem_req, mem_addr          - instruction read request / address
//   mem_ack, mem_rdata         - one-cycle response with its data
//   ir, ir_pc, ir_valid        - latched instruction, its address, valid
//   fetch_err                  - sticky watchdog flag
module fetch_unit
  import zepto_fetch_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] pc_next,
  input  logic              branch_take,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  output logic              fetch_err
);

  fetch_state_e state, state_nxt;
  logic         capture;   // accepted ack: write IR, advance PC
  logic         redirect;  // branch honoured this cycle
  logic         wd_count, wd_clear;

  assign mem_addr = pc_in;

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    pc_next   = pc_in;
    capture   = 1'b0;
    redirect  = 1'b0;
    if (!Reset) begin
      case (state)
        ST_IDLE: state_nxt = ST_FETCH;
        ST_FETCH: begin
          if (branch_take) begin
            // Withdraw the request; any ack this cycle is dropped.
            redirect  = 1'b1;
            pc_next   = branch_target;
          end else if (stall && ir_valid) begin
            // Decode still owns the current word, so a new request would
            // overwrite it: park in HOLD with no request out.
            state_nxt = ST_HOLD;
          end else begin
            mem_req = 1'b1;
            if (mem_ack) begin
              capture = 1'b1;
              pc_next = pc_in + ADDR_W'(PC_INC);
            end
          end
        end
        ST_HOLD: begin
          if (branch_take) begin
            redirect  = 1'b1;
            pc_next   = branch_target;
            state_nxt = ST_FETCH;
          end else if (!stall) begin
            state_nxt = ST_FETCH;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state    <= ST_IDLE;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        ir    <= mem_rdata;
        ir_pc <= pc_in;
      end
      if (redirect)
        ir_valid <= 1'b0;
      else if (capture)
        ir_valid <= 1'b1;
      else if (ir_valid && !stall)
        ir_valid <= 1'b0;  // consumed by decode
    end
  end

  // mem_req is only ever high in FETCH without a redirect.
  assign wd_count = mem_req && !mem_ack;
  assign wd_clear = capture || redirect || (state_nxt != ST_FETCH);

  fetch_wdog #(.MAX_WAIT(MAX_WAIT)) u_wdog (
    .clk       (clk),
    .Reset     (Reset),
    .count_en  (wd_count),
    .clear     (wd_clear),
    .fetch_err (fetch_err)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        Reset;
  logic [15:0] pc_in, pc_next;
  logic        branch_take;
  logic [15:0] branch_target;
  logic        stall;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] ir, ir_pc;
  logic        ir_valid, fetch_err;

  int total = 0;
  int bad   = 0;

  fetch_unit #(.DATA_W(16), .ADDR_W(16), .MAX_WAIT(15)) dut (
    .clk           (clk),
    .Reset         (Reset),
    .pc_in         (pc_in),
    .pc_next       (pc_next),
    .branch_take   (branch_take),
    .branch_target (branch_target),
    .stall         (stall),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .ir            (ir),
    .ir_pc         (ir_pc),
    .ir_valid      (ir_valid),
    .fetch_err     (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program counter register: loads pc_next every cycle, clears on reset.
  always @(posedge clk) begin
    if (Reset) pc_in <= 16'h0000;
    else       pc_in <= pc_next;
  end

  // Memory returns addr ^ 0xA5A5; the ack pulse is steered by the sequence.
  assign mem_rdata = mem_addr ^ 16'hA5A5;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    Reset = 1'b1; stall = 1'b0; branch_take = 1'b0;
    branch_target = 16'h0000; mem_ack = 1'b1;

    // Reset held for three edges
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("rst_req",   32'(mem_req),   32'd0);
      chk("rst_valid", 32'(ir_valid),  32'd0);
      chk("rst_ir",    32'(ir),        32'h0);
      chk("rst_irpc",  32'(ir_pc),     32'h0);
      chk("rst_err",   32'(fetch_err), 32'd0);
      chk("rst_pcn",   32'(pc_next),   32'(pc_in));
    end
    Reset = 1'b0; #1;
    // cycle 0: IDLE
    chk("idle_req", 32'(mem_req), 32'd0);
    chk("idle_pcn", 32'(pc_next), 32'h0);

    // cycle 1: first request at PC 0
    cyc(); #1;
    chk("c1_req",   32'(mem_req),  32'd1);
    chk("c1_addr",  32'(mem_addr), 32'h0000);
    chk("c1_pcn",   32'(pc_next),  32'h0001);
    chk("c1_valid", 32'(ir_valid), 32'd0);
    // cycles 2..4: one word per cycle
    cyc(); #1;
    chk("c2_valid", 32'(ir_valid), 32'd1);
    chk("c2_ir",    32'(ir),       32'hA5A5);
    chk("c2_irpc",  32'(ir_pc),    32'h0000);
    chk("c2_addr",  32'(mem_addr), 32'h0001);
    cyc(); #1;
    chk("c3_ir",    32'(ir),       32'hA5A4);
    chk("c3_irpc",  32'(ir_pc),    32'h0001);
    chk("c3_addr",  32'(mem_addr), 32'h0002);
    cyc(); #1;
    chk("c4_ir",    32'(ir),       32'hA5A7);
    chk("c4_irpc",  32'(ir_pc),    32'h0002);

    // Redirect to 0x0010, then ack delayed three cycles
    branch_take = 1'b1; branch_target = 16'h0010; mem_ack = 1'b0; #1;
    chk("br10_pcn", 32'(pc_next), 32'h0010);
    chk("br10_req", 32'(mem_req), 32'd0);
    cyc(); branch_take = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wait_req",   32'(mem_req),  32'd1);
      chk("wait_addr",  32'(mem_addr), 32'h0010);
      chk("wait_pcn",   32'(pc_next),  32'h0010);
      chk("wait_valid", 32'(ir_valid), 32'd0);
      cyc();
    end
    mem_ack = 1'b1; #1;
    chk("ack_req",  32'(mem_req),  32'd1);
    chk("ack_addr", 32'(mem_addr), 32'h0010);
    chk("ack_pcn",  32'(pc_next),  32'h0011);
    cyc(); #1;
    chk("dly_valid", 32'(ir_valid), 32'd1);
    chk("dly_ir",    32'(ir),       32'hA5B5);
    chk("dly_irpc",  32'(ir_pc),    32'h0010);
    chk("dly_pc",    32'(pc_in),    32'h0011);

    // Stall for four cycles with a valid word
    stall = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      chk("stl_req",   32'(mem_req),  32'd0);
      chk("stl_pcn",   32'(pc_next),  32'h0011);
      chk("stl_ir",    32'(ir),       32'hA5B5);
      chk("stl_valid", 32'(ir_valid), 32'd1);
      cyc(); #1;
    end
    stall = 1'b0; #1;
    chk("unstl_req", 32'(mem_req), 32'd0);
    chk("unstl_pcn", 32'(pc_next), 32'h0011);
    cyc(); #1;
    chk("resume_req",   32'(mem_req),  32'd1);
    chk("resume_addr",  32'(mem_addr), 32'h0011);
    chk("resume_valid", 32'(ir_valid), 32'd0);
    cyc(); #1;
    chk("resume_ir", 32'(ir), 32'hA5B4);

    // Branch to 0x0200 in the same cycle as an ack
    branch_take = 1'b1; branch_target = 16'h0200; #1;
    chk("brack_req", 32'(mem_req), 32'd0);
    chk("brack_pcn", 32'(pc_next), 32'h0200);
    cyc(); branch_take = 1'b0; #1;
    chk("brack_valid", 32'(ir_valid), 32'd0);
    chk("brack_ir",    32'(ir),       32'hA5B4);
    chk("brack_addr",  32'(mem_addr), 32'h0200);
    cyc(); #1;
    chk("br_new_valid", 32'(ir_valid), 32'd1);
    chk("br_new_irpc",  32'(ir_pc),    32'h0200);
    chk("br_new_ir",    32'(ir),       32'hA7A5);

    // PC wrap at 0xFFFF
    branch_take = 1'b1; branch_target = 16'hFFFF;
    cyc(); branch_take = 1'b0; #1;
    chk("wrap_addr", 32'(mem_addr), 32'hFFFF);
    chk("wrap_pcn",  32'(pc_next),  32'h0000);
    cyc(); #1;
    chk("wrap_irpc", 32'(ir_pc), 32'hFFFF);
    chk("wrap_ir",   32'(ir),    32'h5A5A);
    chk("wrap_pc",   32'(pc_in), 32'h0000);

    // Watchdog: no ack for 15 waiting cycles
    mem_ack = 1'b0; #1;
    for (int i = 0; i < 15; i++) begin
      chk("wd_pre_err", 32'(fetch_err), 32'd0);
      chk("wd_req",     32'(mem_req),   32'd1);
      cyc(); #1;
    end
    chk("wd_err",      32'(fetch_err), 32'd1);
    chk("wd_req_held", 32'(mem_req),   32'd1);
    mem_ack = 1'b1;
    cyc(); #1;
    chk("wd_sticky",   32'(fetch_err), 32'd1);
    chk("wd_ack_valid", 32'(ir_valid), 32'd1);
    Reset = 1'b1;
    cyc(); #1;
    chk("wd_rst_err",   32'(fetch_err), 32'd0);
    chk("wd_rst_valid", 32'(ir_valid),  32'd0);
    chk("wd_rst_req",   32'(mem_req),   32'd0);
    chk("wd_rst_ir",    32'(ir),        32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
